// File: rtl/beamscaler_wb_reader_pkg.sv
// Shared beam-scaler definitions: reader FSM states, scaler address map,
// header tag and the fill word used for failed reads.
package beamscaler_wb_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_REQ,
    ST_PUSH,
    ST_FIN
  } state_t;

  // Scaler address map, shared with the scaler target.
  localparam int ADR_W        = 12;
  localparam int ADR_HALF_BIT = 10;
  localparam int ADR_IDX_MSB  = 8;
  localparam int ADR_IDX_LSB  = 2;
  localparam int IDX_W        = ADR_IDX_MSB - ADR_IDX_LSB + 1;

  localparam logic [15:0] HDR_TAG_DEFAULT = 16'hBE5C;
  localparam logic [31:0] FILL_WORD       = 32'hDEAD_DEAD;

  function automatic logic [ADR_W-1:0] scaler_adr(input logic half,
                                                  input logic [IDX_W-1:0] idx);
    logic [ADR_W-1:0] adr;
    adr = '0;
    adr[ADR_HALF_BIT] = half;
    adr[ADR_IDX_MSB:ADR_IDX_LSB] = idx;
    return adr;
  endfunction

  // Header layout: tag in [31:16], bank in bit 8, words-per-half in [7:0].
  function automatic logic [31:0] header_word(input logic [15:0] tag,
                                              input logic bank,
                                              input logic [7:0] nwords);
    return {tag, 7'd0, bank, nwords};
  endfunction

endpackage

// File: rtl/beamscaler_wb_reader_wb_read_timeout.sv
// Response watchdog for one WISHBONE read: counts cycles spent waiting and
// flags expiry once the count reaches TIMEOUT.
module wb_read_timeout #(
  parameter int TIMEOUT = 63
) (
  input  logic clk,
  input  logic srst,
  input  logic start,
  input  logic run,
  output logic expired
);
  localparam int               CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Holds at LIMIT so a stalled request can never wrap back below it.
  always_comb begin
    cnt_next = cnt_reg;
    if (start) begin
      cnt_next = '0;
    end else if (run && (cnt_reg != LIMIT)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign expired = run && (cnt_reg == LIMIT);

endmodule

// File: rtl/beamscaler_wb_reader.sv
// Drains one beam-scaler bank over WISHBONE after each period-done strobe and
// emits it as a single header-prefixed packet on a ready/valid stream.
module beamscaler_wb_reader
  import beamscaler_wb_reader_pkg::*;
#(
  parameter int          NWORDS  = 46,
  parameter int          TIMEOUT = 63,
  parameter logic [15:0] HDR_TAG = HDR_TAG_DEFAULT
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             done_i,
  input  logic             bank_i,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [31:0]      wb_dat_o,
  output logic [3:0]       wb_sel_o,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  input  logic             wb_rty_i,
  output logic [31:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             busy_o,
  output logic             overrun_o,
  output logic [7:0]       err_cnt_o
);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NWORDS - 1);
  localparam logic [7:0]       NWORDS_HDR = 8'(NWORDS);

  state_t           state_reg, state_next;
  logic             bank_reg;
  logic             half_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [31:0]      word_reg;
  logic [7:0]       err_cnt_reg;
  logic             overrun_reg;

  logic tmo_start, tmo_run, tmo_expired;
  logic rsp_fail, rsp_any, last_beat;

  assign last_beat = half_reg && (idx_reg == LAST_IDX);
  assign rsp_fail  = wb_err_i || wb_rty_i || tmo_expired;
  assign rsp_any   = wb_ack_i || rsp_fail;
  assign tmo_run   = (state_reg == ST_REQ);
  assign tmo_start = (state_next == ST_REQ) && (state_reg != ST_REQ);

  wb_read_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (wb_clk_i),
    .srst   (wb_rst_i),
    .start  (tmo_start),
    .run    (tmo_run),
    .expired(tmo_expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (done_i)   state_next = ST_HDR;
      ST_HDR:  if (m_tready) state_next = ST_REQ;
      ST_REQ:  if (rsp_any)  state_next = ST_PUSH;
      ST_PUSH: if (m_tready) state_next = last_beat ? ST_FIN : ST_REQ;
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_adr_o = '0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    busy_o   = (state_reg != ST_IDLE);
    unique case (state_reg)
      ST_HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = header_word(HDR_TAG, bank_reg, NWORDS_HDR);
      end
      ST_REQ: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_adr_o = scaler_adr(half_reg, idx_reg);
      end
      ST_PUSH: begin
        m_tvalid = 1'b1;
        m_tdata  = word_reg;
        m_tlast  = last_beat;
      end
      default: ;
    endcase
  end

  // Datapath: bank latch, read pointer, captured word and status counters.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bank_reg    <= 1'b0;
      half_reg    <= 1'b0;
      idx_reg     <= '0;
      word_reg    <= '0;
      err_cnt_reg <= '0;
      overrun_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (done_i) begin
            bank_reg <= bank_i;
            half_reg <= 1'b0;
            idx_reg  <= '0;
          end
        end
        ST_REQ: begin
          // An ack wins over a simultaneous failure or timeout.
          if (wb_ack_i) begin
            word_reg <= wb_dat_i;
          end else if (rsp_fail) begin
            word_reg <= FILL_WORD;
            if (err_cnt_reg != 8'hFF) begin
              err_cnt_reg <= err_cnt_reg + 8'd1;
            end
          end
        end
        ST_PUSH: begin
          if (m_tready && !last_beat) begin
            if (idx_reg == LAST_IDX) begin
              half_reg <= 1'b1;
              idx_reg  <= '0;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        default: ;
      endcase
      if (done_i && (state_reg != ST_IDLE)) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign wb_we_o   = 1'b0;
  assign wb_dat_o  = '0;
  assign wb_sel_o  = 4'hF;
  assign overrun_o = overrun_reg;
  assign err_cnt_o = err_cnt_reg;

endmodule

// File: tb/tb_beamscaler_wb_reader.sv
// Directed bench for beamscaler_wb_reader: scaler target model, stream sink and
// per-packet checks of data, framing, timing and status outputs.
module tb_beamscaler_wb_reader;
  localparam int          NW     = 46;
  localparam int          TMO    = 63;
  localparam int          NBEATS = 2 * NW + 1;
  localparam logic [31:0] FILL   = 32'hDEAD_DEAD;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        done_i   = 1'b0;
  logic        bank_i   = 1'b0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [11:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_rty_i = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        busy_o, overrun_o;
  logic [7:0]  err_cnt_o;

  always #5 wb_clk_i = ~wb_clk_i;

  beamscaler_wb_reader #(
    .NWORDS (NW),
    .TIMEOUT(TMO),
    .HDR_TAG(16'hBE5C)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .done_i   (done_i),
    .bank_i   (bank_i),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .wb_rty_i (wb_rty_i),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .busy_o   (busy_o),
    .overrun_o(overrun_o),
    .err_cnt_o(err_cnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Target model: 0 normal, 1 ignores half0/idx5, 2 err on idx0 and rty on idx1.
  int          tgt_mode = 0;
  int          stb_cnt  = 0;
  logic [11:0] rd_adr[$];
  int          rd_len[$];
  int          cyc_viol = 0;

  always @(negedge wb_clk_i) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    wb_dat_i = '0;
    if (wb_cyc_o && wb_stb_o) begin
      if (stb_cnt == 0) rd_adr.push_back(wb_adr_o);
      stb_cnt++;
      if (stb_cnt == 4) begin
        if (tgt_mode == 1 && wb_adr_o == 12'h014) begin
          wb_ack_i = 1'b0;
        end else if (tgt_mode == 2 && wb_adr_o == 12'h000) begin
          wb_err_i = 1'b1;
        end else if (tgt_mode == 2 && wb_adr_o == 12'h004) begin
          wb_rty_i = 1'b1;
        end else begin
          wb_ack_i = 1'b1;
          wb_dat_i = {24'd0, wb_adr_o[10], wb_adr_o[8:2]};
        end
      end
    end else begin
      if (stb_cnt != 0) rd_len.push_back(stb_cnt);
      stb_cnt = 0;
    end
    if (wb_cyc_o && m_tvalid) cyc_viol++;
  end

  // Stream sink: records each beat that will transfer on the next rising edge.
  int          bp_mode = 0;
  int          cyc_n   = 0;
  logic [31:0] beat_data[$];
  logic        beat_last[$];
  int          beat_cyc[$];
  logic        stall_pending = 1'b0;
  logic [31:0] stall_data    = '0;
  int          stall_viol    = 0;
  logic        last_pending  = 1'b0;

  always @(negedge wb_clk_i) begin
    logic tr;
    cyc_n++;
    tr = (bp_mode != 0) ? ($urandom_range(0, 9) < 3) : 1'b1;
    if (wb_rst_i) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending && (!m_tvalid || m_tdata !== stall_data)) stall_viol++;
      if (m_tvalid && tr) begin
        beat_data.push_back(m_tdata);
        beat_last.push_back(m_tlast);
        beat_cyc.push_back(cyc_n);
        if (m_tlast) last_pending = 1'b1;
        stall_pending = 1'b0;
      end else if (m_tvalid) begin
        stall_pending = 1'b1;
        stall_data    = m_tdata;
      end else begin
        stall_pending = 1'b0;
      end
    end
    m_tready = tr;
  end

  function automatic logic [31:0] exp_word(input int k, input logic bank, input int mode);
    int h;
    int i;
    if (k == 0) return {16'hBE5C, 7'd0, bank, 8'd46};
    h = (k - 1) / NW;
    i = (k - 1) % NW;
    if (mode == 1 && h == 0 && i == 5) return FILL;
    if (mode == 2 && h == 0 && i < 2) return FILL;
    return 32'(h * 128 + i);
  endfunction

  task automatic clear_capture();
    beat_data.delete();
    beat_last.delete();
    beat_cyc.delete();
    rd_adr.delete();
    rd_len.delete();
    last_pending = 1'b0;
    cyc_viol     = 0;
    stall_viol   = 0;
  endtask

  task automatic do_reset();
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
  endtask

  task automatic start_packet(input logic bank);
    clear_capture();
    @(posedge wb_clk_i); #1;
    bank_i = bank;
    done_i = 1'b1;
    @(posedge wb_clk_i); #1;
    done_i = 1'b0;
    bank_i = ~bank;
  endtask

  // Returns at the rising edge on which the tlast beat transfers.
  task automatic wait_packet();
    int n;
    n = 0;
    while (!last_pending && n < 20000) begin
      @(posedge wb_clk_i);
      n++;
    end
    check_val("pkt_end", 32'(last_pending), 1);
  endtask

  task automatic check_packet(input string tag, input logic bank, input int mode);
    int n_last;
    int last_pos;
    n_last   = 0;
    last_pos = -1;
    check_val({tag, "_beats"}, 32'(beat_data.size()), NBEATS);
    for (int k = 0; k < beat_data.size() && k < NBEATS; k++) begin
      check_val($sformatf("%s_w%0d", tag, k), beat_data[k], exp_word(k, bank, mode));
    end
    for (int k = 0; k < beat_last.size(); k++) begin
      if (beat_last[k]) begin
        n_last++;
        last_pos = k;
      end
    end
    check_val({tag, "_tlast_cnt"}, 32'(n_last), 1);
    check_val({tag, "_tlast_pos"}, 32'(last_pos), NBEATS - 1);
    check_val({tag, "_reads"}, 32'(rd_adr.size()), 2 * NW);
    check_val({tag, "_stall_stable"}, 32'(stall_viol), 0);
    check_val({tag, "_cyc_vs_tvalid"}, 32'(cyc_viol), 0);
    $display("packet %s: %0d beats, %0d reads, err_cnt=%0d, overrun=%0d",
             tag, beat_data.size(), rd_adr.size(), err_cnt_o, overrun_o);
  endtask

  initial begin
    int n;
    int n_last;

    // Reset values
    repeat (3) @(posedge wb_clk_i);
    #1;
    check_val("rst_cyc", 32'(wb_cyc_o), 0);
    check_val("rst_stb", 32'(wb_stb_o), 0);
    check_val("rst_tvalid", 32'(m_tvalid), 0);
    check_val("rst_tlast", 32'(m_tlast), 0);
    check_val("rst_busy", 32'(busy_o), 0);
    check_val("rst_overrun", 32'(overrun_o), 0);
    check_val("rst_err_cnt", 32'(err_cnt_o), 0);
    check_val("rst_adr", 32'(wb_adr_o), 0);
    check_val("rst_tdata", m_tdata, 0);
    check_val("we_const", 32'(wb_we_o), 0);
    check_val("sel_const", 32'(wb_sel_o), 32'hF);
    check_val("dat_o_const", wb_dat_o, 0);
    wb_rst_i = 1'b0;

    // Nominal packet, bank 1, tready tied high
    start_packet(1'b1);
    check_val("lat_busy", 32'(busy_o), 1);
    check_val("lat_tvalid", 32'(m_tvalid), 1);
    check_val("lat_hdr", m_tdata, 32'hBE5C_012E);
    wait_packet();
    @(posedge wb_clk_i); #1;
    check_val("nom_busy_idle", 32'(busy_o), 0);
    check_packet("nom", 1'b1, 0);
    if (rd_adr.size() > NW) check_val("nom_adr_half1", 32'(rd_adr[NW]), 32'h400);
    else check_val("nom_adr_half1_present", 32'(rd_adr.size()), NW + 1);
    if (beat_cyc.size() > 2) check_val("nom_word_cycles", 32'(beat_cyc[2] - beat_cyc[1]), 5);
    else check_val("nom_word_cycles_present", 32'(beat_cyc.size()), 3);
    check_val("nom_err_cnt", 32'(err_cnt_o), 0);
    check_val("nom_overrun", 32'(overrun_o), 0);

    // Backpressure: tready high about 30% of cycles
    bp_mode = 1;
    start_packet(1'b0);
    wait_packet();
    @(posedge wb_clk_i); #1;
    bp_mode = 0;
    check_packet("bp", 1'b0, 0);

    // Timeout on half0/idx5
    do_reset();
    tgt_mode = 1;
    start_packet(1'b1);
    wait_packet();
    @(posedge wb_clk_i); #1;
    check_packet("tmo", 1'b1, 1);
    check_val("tmo_err_cnt", 32'(err_cnt_o), 1);
    if (rd_len.size() > 5) begin
      check_val("tmo_stb_len", 32'(rd_len[5]), TMO + 1);
      check_val("tmo_nominal_len", 32'(rd_len[4]), 4);
    end else begin
      check_val("tmo_len_present", 32'(rd_len.size()), 6);
    end
    if (rd_adr.size() > 6) check_val("tmo_next_adr", 32'(rd_adr[6]), 32'h018);
    else check_val("tmo_next_present", 32'(rd_adr.size()), 7);

    // err on idx0, rty on idx1
    do_reset();
    tgt_mode = 2;
    start_packet(1'b0);
    wait_packet();
    @(posedge wb_clk_i); #1;
    check_packet("errrty", 1'b0, 2);
    check_val("errrty_err_cnt", 32'(err_cnt_o), 2);
    if (rd_adr.size() > 2) check_val("errrty_third_adr", 32'(rd_adr[2]), 32'h008);
    else check_val("errrty_third_present", 32'(rd_adr.size()), 3);

    // Overrun mid-packet and in FIN; done in first IDLE cycle starts a packet
    do_reset();
    tgt_mode = 0;
    start_packet(1'b1);
    repeat (100) @(posedge wb_clk_i);
    #1;
    done_i = 1'b1;
    bank_i = 1'b0;
    @(posedge wb_clk_i); #1;
    done_i = 1'b0;
    check_val("ovr_mid", 32'(overrun_o), 1);
    wait_packet();
    check_packet("ovr", 1'b1, 0);
    #1;
    done_i = 1'b1;
    bank_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check_val("ovr_fin_ignored", 32'(busy_o), 0);
    check_val("ovr_sticky", 32'(overrun_o), 1);
    @(posedge wb_clk_i); #1;
    done_i = 1'b0;
    bank_i = 1'b1;
    clear_capture();
    check_val("ovr_new_busy", 32'(busy_o), 1);
    check_val("ovr_new_hdr", m_tdata, 32'hBE5C_002E);
    wait_packet();
    @(posedge wb_clk_i); #1;
    check_packet("ovr_next", 1'b0, 0);

    // Reset while strobing half0/idx10
    do_reset();
    start_packet(1'b0);
    n = 0;
    while (!(wb_stb_o && wb_adr_o == 12'h028) && n < 2000) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    check_val("rst_mid_reached", 32'(wb_stb_o), 1);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check_val("rstm_cyc", 32'(wb_cyc_o), 0);
    check_val("rstm_stb", 32'(wb_stb_o), 0);
    check_val("rstm_tvalid", 32'(m_tvalid), 0);
    check_val("rstm_tlast", 32'(m_tlast), 0);
    check_val("rstm_busy", 32'(busy_o), 0);
    check_val("rstm_err_cnt", 32'(err_cnt_o), 0);
    check_val("rstm_overrun", 32'(overrun_o), 0);
    check_val("rstm_adr", 32'(wb_adr_o), 0);
    check_val("rstm_tdata", m_tdata, 0);
    n_last = 0;
    for (int k = 0; k < beat_last.size(); k++) if (beat_last[k]) n_last++;
    check_val("rstm_no_tlast", 32'(n_last), 0);
    wb_rst_i = 1'b0;
    start_packet(1'b1);
    wait_packet();
    @(posedge wb_clk_i); #1;
    check_packet("post_rst", 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
